// File: rtl/pc_sequencer.sv
// pc_sequencer
// ------------
// Fetch-side program counter owner. It consumes the main-control transfer
// flags for the instruction in decode and resolves JR / JUMP / CALL and the
// conditional branches (BZ, GZ, LZ). A taken redirect raises a one-cycle
// combinational flush that kills the wrong-path fetch, and loads the target
// at the next edge. A taken CALL also writes the return address with a
// one-cycle registered strobe.
//
// Parameters:
//   PC_W      width of the PC and all address ports
//   RESET_PC  PC value loaded on reset
//   PC_STEP   sequential increment (word-addressed instruction memory)
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               freezes PC and suppresses redirects
//   turn_off            halt request (sticky HALT until reset)
//   dec_valid, dec_pc   decode-stage instruction is real; its PC
//   Call, jump_F, JR_F,
//   BZ, GZ, LZ          transfer flags for the decode instruction
//   rs_value            source register value compared against zero
//   branch_offset       sign-extended branch offset
//   jump_target         absolute JUMP/CALL target
//   jr_target           register target for JR
//   pc, pc_valid        fetch address and its qualifier
//   flush               kill the instruction currently in fetch
//   ret_addr, ret_we    CALL return address and its one-cycle strobe
//   halted              core stopped
//   redirect_count      taken-redirect counter (0 unless enabled)
//   state_dbg           current FSM state (BOOT=0, RUN=1, HALT=2)
//
// Optional feature: define PC_SEQ_REDIRECT_CNT_EN to build the saturating
// taken-redirect counter; otherwise redirect_count is tied to zero.
//
// Handshake: there is no backpressure. pc is a fetch request whenever
// pc_valid=1; flush and ret_we are single-cycle strobes with no acknowledge.

module pc_sequencer #(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter int unsigned         PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            turn_off,
  input  logic            dec_valid,
  input  logic [PC_W-1:0] dec_pc,
  input  logic            Call,
  input  logic            jump_F,
  input  logic            JR_F,
  input  logic            BZ,
  input  logic            GZ,
  input  logic            LZ,
  input  logic [31:0]     rs_value,
  input  logic [PC_W-1:0] branch_offset,
  input  logic [PC_W-1:0] jump_target,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic            flush,
  output logic [PC_W-1:0] ret_addr,
  output logic            ret_we,
  output logic            halted,
  output logic [15:0]     redirect_count,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [1:0]      state;
  logic            sel_taken;
  logic            sel_call;
  logic [PC_W-1:0] sel_target;
  logic [PC_W-1:0] branch_target;
  logic            rs_zero;
  logic            rs_neg;
  logic            take;

  assign branch_target = dec_pc + branch_offset;  // wraps modulo 2^PC_W
  assign rs_zero       = (rs_value == 32'd0);
  assign rs_neg        = rs_value[31];

  // The highest-priority flag alone decides; a lower flag never rescues a
  // not-taken higher one (illegal multi-flag encodings resolve by priority).
  always_comb begin
    sel_taken  = 1'b0;
    sel_call   = 1'b0;
    sel_target = branch_target;
    if (JR_F) begin
      sel_taken  = 1'b1;
      sel_target = jr_target;
    end else if (jump_F) begin
      sel_taken  = 1'b1;
      sel_target = jump_target;
    end else if (Call) begin
      sel_taken  = 1'b1;
      sel_call   = 1'b1;
      sel_target = jump_target;
    end else if (BZ) begin
      sel_taken  = rs_zero;
    end else if (GZ) begin
      sel_taken  = !rs_neg && !rs_zero;
    end else if (LZ) begin
      sel_taken  = rs_neg;
    end
  end

  // turn_off and stall both veto the redirect in the same cycle.
  assign take     = (state == RUN) && !turn_off && !stall && dec_valid && sel_taken;
  assign flush    = take;
  assign pc_valid = (state == RUN);
  assign halted   = (state == HALT);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      ret_addr <= '0;
      ret_we   <= 1'b0;
    end else begin
      ret_we <= 1'b0;
      case (state)
        BOOT: begin
          state <= turn_off ? HALT : RUN;
        end
        RUN: begin
          if (turn_off) begin
            state <= HALT;
          end else if (stall) begin
            pc <= pc;
          end else if (take) begin
            pc <= sel_target;
            if (sel_call) begin
              ret_addr <= dec_pc + STEP;
              ret_we   <= 1'b1;
            end
          end else begin
            pc <= pc + STEP;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef PC_SEQ_REDIRECT_CNT_EN
  logic [15:0] cnt;

  // take is already false outside RUN, so the count freezes in HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 16'd0;
    end else if (take && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign redirect_count = cnt;
`else
  assign redirect_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed per-cycle vectors with hand-computed
// expected outputs pushed into a queue by the driver; a negedge monitor pops
// and compares one expected record per driven cycle.

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        turn_off;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic        Call, jump_F, JR_F, BZ, GZ, LZ;
  logic [31:0] rs_value;
  logic [31:0] branch_offset;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic [31:0] ret_addr;
  logic        ret_we;
  logic        halted;
  logic [15:0] redirect_count;
  logic [1:0]  state_dbg;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        we;
    logic [31:0] ra;
    logic        halted;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [15:0] cnt_model = 16'd0;
  bit    driver_done = 1'b0;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0), .PC_STEP(1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .turn_off(turn_off),
    .dec_valid(dec_valid), .dec_pc(dec_pc),
    .Call(Call), .jump_F(jump_F), .JR_F(JR_F), .BZ(BZ), .GZ(GZ), .LZ(LZ),
    .rs_value(rs_value), .branch_offset(branch_offset),
    .jump_target(jump_target), .jr_target(jr_target),
    .pc(pc), .pc_valid(pc_valid), .flush(flush),
    .ret_addr(ret_addr), .ret_we(ret_we), .halted(halted),
    .redirect_count(redirect_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    stall = 0; turn_off = 0; dec_valid = 0; dec_pc = '0;
    Call = 0; jump_F = 0; JR_F = 0; BZ = 0; GZ = 0; LZ = 0;
    rs_value = '0; branch_offset = '0; jump_target = '0; jr_target = '0;
  endtask

  // Move to the next cycle (just after the rising edge) with idle inputs;
  // reset keeps whatever the caller last set.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic expect_out(input logic [31:0] e_pc, input logic e_valid,
                            input logic e_flush, input logic e_we,
                            input logic [31:0] e_ra, input logic e_halted);
    exp_t e;
    e.pc = e_pc; e.valid = e_valid; e.flush = e_flush; e.we = e_we;
    e.ra = e_ra; e.halted = e_halted;
`ifdef PC_SEQ_REDIRECT_CNT_EN
    e.cnt = cnt_model;
`else
    e.cnt = 16'd0;
`endif
    exp_q.push_back(e);
    // Count visible next cycle: cleared by reset, bumped by a taken redirect.
    if (reset) cnt_model = 16'd0;
    else if (e_flush && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc",             pc,                     e.pc);
        chk("pc_valid",       {31'd0, pc_valid},      {31'd0, e.valid});
        chk("flush",          {31'd0, flush},         {31'd0, e.flush});
        chk("ret_we",         {31'd0, ret_we},        {31'd0, e.we});
        chk("ret_addr",       ret_addr,               e.ra);
        chk("halted",         {31'd0, halted},        {31'd0, e.halted});
        chk("redirect_count", {16'd0, redirect_count}, {16'd0, e.cnt});
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    // Reset already applied at one edge.
    reset = 1'b1;                 expect_out(32'h0, 0, 0, 0, 32'h0, 0);
    next_cycle(); reset = 1'b0;   expect_out(32'h0, 0, 0, 0, 32'h0, 0); // BOOT
    next_cycle();                 expect_out(32'h0, 1, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h1, 1, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h2, 1, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h3, 1, 0, 0, 32'h0, 0);

    // BZ taken: 0x10 + (-4) = 0x0C
    next_cycle(); dec_valid = 1; BZ = 1; dec_pc = 32'h10; branch_offset = 32'hFFFF_FFFC; rs_value = 0;
    expect_out(32'h4, 1, 1, 0, 32'h0, 0);
    // BZ not taken
    next_cycle(); dec_valid = 1; BZ = 1; dec_pc = 32'h10; branch_offset = 32'hFFFF_FFFC; rs_value = 5;
    expect_out(32'h0C, 1, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h0D, 1, 0, 0, 32'h0, 0);

    // CALL
    next_cycle(); dec_valid = 1; Call = 1; dec_pc = 32'h20; jump_target = 32'h100;
    expect_out(32'h0E, 1, 1, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h100, 1, 0, 1, 32'h21, 0);
    next_cycle();                 expect_out(32'h101, 1, 0, 0, 32'h21, 0);

    // JR under stall, then released
    next_cycle(); dec_valid = 1; JR_F = 1; jr_target = 32'h40; stall = 1;
    expect_out(32'h102, 1, 0, 0, 32'h21, 0);
    next_cycle(); dec_valid = 1; JR_F = 1; jr_target = 32'h40;
    expect_out(32'h102, 1, 1, 0, 32'h21, 0);
    next_cycle();                 expect_out(32'h40, 1, 0, 0, 32'h21, 0);

    // JR and BZ both set: JR wins
    next_cycle(); dec_valid = 1; JR_F = 1; BZ = 1; jr_target = 32'h80; rs_value = 0;
    dec_pc = 32'h0; branch_offset = 32'h4;
    expect_out(32'h41, 1, 1, 0, 32'h21, 0);
    // GZ with negative value: not taken
    next_cycle(); dec_valid = 1; GZ = 1; rs_value = 32'hFFFF_FFFF; dec_pc = 32'h50; branch_offset = 32'h10;
    expect_out(32'h80, 1, 0, 0, 32'h21, 0);
    // GZ with positive value: 0x50 + 0x10 = 0x60
    next_cycle(); dec_valid = 1; GZ = 1; rs_value = 32'h7; dec_pc = 32'h50; branch_offset = 32'h10;
    expect_out(32'h81, 1, 1, 0, 32'h21, 0);
    // LZ with negative value: 0x30 + 2 = 0x32
    next_cycle(); dec_valid = 1; LZ = 1; rs_value = 32'h8000_0000; dec_pc = 32'h30; branch_offset = 32'h2;
    expect_out(32'h60, 1, 1, 0, 32'h21, 0);
    // Bubble in decode: flags ignored
    next_cycle(); dec_valid = 0; jump_F = 1; jump_target = 32'h500;
    expect_out(32'h32, 1, 0, 0, 32'h21, 0);
    // Jump to top of address space, then sequential wrap
    next_cycle(); dec_valid = 1; jump_F = 1; jump_target = 32'hFFFF_FFFF;
    expect_out(32'h33, 1, 1, 0, 32'h21, 0);
    next_cycle();                 expect_out(32'hFFFF_FFFF, 1, 0, 0, 32'h21, 0);
    // Branch target wraps: 0xFFFFFFFE + 3 = 1
    next_cycle(); dec_valid = 1; BZ = 1; rs_value = 0; dec_pc = 32'hFFFF_FFFE; branch_offset = 32'h3;
    expect_out(32'h0, 1, 1, 0, 32'h21, 0);

    // turn_off coincident with taken jump
    next_cycle(); dec_valid = 1; jump_F = 1; jump_target = 32'h200; turn_off = 1;
    expect_out(32'h1, 1, 0, 0, 32'h21, 0);
    next_cycle(); dec_valid = 1; jump_F = 1; jump_target = 32'h300;
    expect_out(32'h1, 0, 0, 0, 32'h21, 1);
    next_cycle(); dec_valid = 1; Call = 1; jump_target = 32'h300;
    expect_out(32'h1, 0, 0, 0, 32'h21, 1);
    next_cycle();                 expect_out(32'h1, 0, 0, 0, 32'h21, 1);
    // Reset leaves HALT
    next_cycle(); reset = 1;      expect_out(32'h1, 0, 0, 0, 32'h21, 1);
    next_cycle(); reset = 0;      expect_out(32'h0, 0, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h0, 1, 0, 0, 32'h0, 0);
    next_cycle();                 expect_out(32'h1, 1, 0, 0, 32'h0, 0);
    driver_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int budget;
    budget = 0;
    while (!(driver_done && exp_q.size() == 0) && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || !driver_done) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending records", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
